// File: rtl/rf_dbg_pkg.sv
// Shared definitions for the register-file debug port: op encodings, FSM states
// and the register address width used by both the port and the register file.
package rf_dbg_pkg;

    localparam int RF_ADDR_W = 5;

    localparam logic [1:0] OP_READ    = 2'b00;
    localparam logic [1:0] OP_WRITE   = 2'b01;
    localparam logic [1:0] OP_DUMP    = 2'b10;
    localparam logic [1:0] OP_ILLEGAL = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_HALT_WAIT = 2'd1,
        ST_EXEC      = 2'd2,
        ST_RESP      = 2'd3
    } rf_dbg_state_e;

endpackage

// File: rtl/reg_file_dbg_port_if.sv
// Debug host command/response channel; master is the host, slave is the debug port.
interface reg_file_dbg_port_if #(
    parameter int XLEN = 32
);
    import rf_dbg_pkg::*;

    logic                 cmd_valid;
    logic                 cmd_ready;
    logic [1:0]           cmd_op;
    logic [RF_ADDR_W-1:0] cmd_addr;
    logic [XLEN-1:0]      cmd_wdata;

    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [RF_ADDR_W-1:0] rsp_addr;
    logic [XLEN-1:0]      rsp_data;
    logic                 rsp_last;
    logic                 rsp_err;

    modport master (
        output cmd_valid, cmd_op, cmd_addr, cmd_wdata, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_addr, rsp_data, rsp_last, rsp_err
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_addr, cmd_wdata, rsp_ready,
        output cmd_ready, rsp_valid, rsp_addr, rsp_data, rsp_last, rsp_err
    );

endinterface

// File: rtl/reg_file_dbg_port.sv
// Debug initiator: halts the core, then drives the register file A1/RD1 and WE3/A3/WD3 ports.
//   state     | meaning
//   IDLE      | ready for a host command
//   HALT_WAIT | halt requested, waiting for dbg_halted (with timeout)
//   EXEC      | one cycle driving the register file ports
//   RESP      | response held until rsp_ready
module reg_file_dbg_port
    import rf_dbg_pkg::*;
#(
    parameter int XLEN         = 32,
    parameter int NREGS        = 32,
    parameter int HALT_TIMEOUT = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    reg_file_dbg_port_if.slave   bus,
    output logic                 dbg_halt_req,
    input  logic                 dbg_halted,
    output logic [RF_ADDR_W-1:0] rf_raddr,
    input  logic [XLEN-1:0]      rf_rdata,
    output logic                 rf_we,
    output logic [RF_ADDR_W-1:0] rf_waddr,
    output logic [XLEN-1:0]      rf_wdata
);

    localparam int                   TMO_W    = $clog2(HALT_TIMEOUT + 1);
    localparam logic [TMO_W-1:0]     TMO_LAST = TMO_W'(HALT_TIMEOUT - 1);
    localparam logic [RF_ADDR_W-1:0] LAST_REG = RF_ADDR_W'(NREGS - 1);

    rf_dbg_state_e        state;
    logic                 rst_done;
    logic [1:0]           op_q;
    logic [RF_ADDR_W-1:0] addr_q;
    logic [XLEN-1:0]      wdata_q;
    logic [RF_ADDR_W-1:0] cnt_q;
    logic [TMO_W-1:0]     tmo_q;
    logic [RF_ADDR_W-1:0] rsp_addr_q;
    logic [XLEN-1:0]      rsp_data_q;
    logic                 rsp_last_q;
    logic                 rsp_err_q;

    // rst_done keeps cmd_ready low while in reset even though state is IDLE
    assign bus.cmd_ready = rst_done && (state == ST_IDLE);
    assign bus.rsp_valid = (state == ST_RESP);
    assign bus.rsp_addr  = rsp_addr_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_last  = rsp_last_q;
    assign bus.rsp_err   = rsp_err_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= ST_IDLE;
            rst_done     <= 1'b0;
            op_q         <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
            cnt_q        <= '0;
            tmo_q        <= '0;
            rsp_addr_q   <= '0;
            rsp_data_q   <= '0;
            rsp_last_q   <= 1'b0;
            rsp_err_q    <= 1'b0;
            dbg_halt_req <= 1'b0;
            rf_raddr     <= '0;
            rf_we        <= 1'b0;
            rf_waddr     <= '0;
            rf_wdata     <= '0;
        end else begin
            rst_done <= 1'b1;
            case (state)
                ST_IDLE: begin
                    if (bus.cmd_valid && rst_done) begin
                        op_q    <= bus.cmd_op;
                        addr_q  <= bus.cmd_addr;
                        wdata_q <= bus.cmd_wdata;
                        cnt_q   <= '0;
                        tmo_q   <= '0;
                        if (bus.cmd_op == OP_ILLEGAL) begin
                            rsp_addr_q <= bus.cmd_addr;
                            rsp_data_q <= '0;
                            rsp_last_q <= 1'b1;
                            rsp_err_q  <= 1'b1;
                            state      <= ST_RESP;
                        end else begin
                            dbg_halt_req <= 1'b1;
                            state        <= ST_HALT_WAIT;
                        end
                    end
                end
                ST_HALT_WAIT: begin
                    if (dbg_halted) begin
                        state <= ST_EXEC;
                        if (op_q == OP_DUMP) begin
                            rf_raddr <= cnt_q;
                        end else if (op_q == OP_READ) begin
                            rf_raddr <= addr_q;
                        end
                        if (op_q == OP_WRITE && addr_q != '0) begin
                            rf_we    <= 1'b1;
                            rf_waddr <= addr_q;
                            rf_wdata <= wdata_q;
                        end
                    end else if (tmo_q == TMO_LAST) begin
                        rsp_addr_q <= addr_q;
                        rsp_data_q <= '0;
                        rsp_last_q <= 1'b1;
                        rsp_err_q  <= 1'b1;
                        state      <= ST_RESP;
                    end else begin
                        tmo_q <= tmo_q + 1'b1;
                    end
                end
                ST_EXEC: begin
                    state     <= ST_RESP;
                    rf_we     <= 1'b0;
                    rf_raddr  <= '0;
                    rsp_err_q <= 1'b0;
                    if (op_q == OP_DUMP) begin
                        rsp_addr_q <= cnt_q;
                        rsp_data_q <= rf_rdata;
                        rsp_last_q <= (cnt_q == LAST_REG);
                    end else if (op_q == OP_WRITE) begin
                        rsp_addr_q <= addr_q;
                        rsp_data_q <= (addr_q == '0) ? '0 : wdata_q;
                        rsp_last_q <= 1'b1;
                    end else begin
                        rsp_addr_q <= addr_q;
                        rsp_data_q <= rf_rdata;
                        rsp_last_q <= 1'b1;
                    end
                end
                ST_RESP: begin
                    if (bus.rsp_ready) begin
                        // an errored dump never walks the registers
                        if (op_q == OP_DUMP && !rsp_err_q && cnt_q != LAST_REG) begin
                            cnt_q    <= cnt_q + 1'b1;
                            rf_raddr <= cnt_q + 1'b1;
                            state    <= ST_EXEC;
                        end else begin
                            dbg_halt_req <= 1'b0;
                            state        <= ST_IDLE;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_reg_file_dbg_port.sv
// Self-checking bench for reg_file_dbg_port: register-file model, directed cases and random commands.
module tb_reg_file_dbg_port;
    import rf_dbg_pkg::*;

    localparam int XLEN         = 32;
    localparam int NREGS        = 32;
    localparam int HALT_TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        dbg_halt_req;
    logic        dbg_halted;
    logic [4:0]  rf_raddr;
    logic [31:0] rf_rdata;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;

    always #5 clk = ~clk;

    reg_file_dbg_port_if #(.XLEN(XLEN)) bus ();

    reg_file_dbg_port #(
        .XLEN(XLEN),
        .NREGS(NREGS),
        .HALT_TIMEOUT(HALT_TIMEOUT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus),
        .dbg_halt_req(dbg_halt_req),
        .dbg_halted(dbg_halted),
        .rf_raddr(rf_raddr),
        .rf_rdata(rf_rdata),
        .rf_we(rf_we),
        .rf_waddr(rf_waddr),
        .rf_wdata(rf_wdata)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ref_regs is the architectural model; env_rf is the register file the DUT really drives
    logic [31:0] ref_regs [NREGS];
    logic [31:0] env_rf   [NREGS];
    bit          preload = 1'b0;
    int          halt_mode = 1;
    int          halt_delay = 0;
    int          hr_cycles = 0;
    int          hr_total = 0;
    int          we_total = 0;
    logic [4:0]  we_last_addr = '0;
    logic [31:0] we_last_data = '0;

    assign rf_rdata   = (rf_raddr == 5'd0) ? 32'd0 : env_rf[rf_raddr];
    assign dbg_halted = (halt_mode == 1) ||
                        (halt_mode == 2 && dbg_halt_req && hr_cycles >= halt_delay);

    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < NREGS; i++) env_rf[i] <= ref_regs[i];
        end else if (rf_we && rf_waddr != 5'd0) begin
            env_rf[rf_waddr] <= rf_wdata;
        end
        hr_cycles <= dbg_halt_req ? hr_cycles + 1 : 0;
        hr_total  <= hr_total + (dbg_halt_req ? 1 : 0);
        if (rf_we) begin
            we_total     <= we_total + 1;
            we_last_addr <= rf_waddr;
            we_last_data <= rf_wdata;
        end
    end

    task automatic check_all_zero(input string tag);
        check_val({tag, "_cmd_ready"}, bus.cmd_ready, 0);
        check_val({tag, "_rsp_valid"}, bus.rsp_valid, 0);
        check_val({tag, "_halt_req"},  dbg_halt_req,  0);
        check_val({tag, "_rf_we"},     rf_we,         0);
        check_val({tag, "_rf_raddr"},  rf_raddr,      0);
        check_val({tag, "_rsp_data"},  bus.rsp_data,  0);
        check_val({tag, "_rsp_addr"},  bus.rsp_addr,  0);
        check_val({tag, "_rsp_last"},  bus.rsp_last,  0);
        check_val({tag, "_rsp_err"},   bus.rsp_err,   0);
    endtask

    // hmode: 0 never halts, 1 halted tied high, 2 halted hdelay cycles after the request
    task automatic run_cmd(input logic [1:0] op, input logic [4:0] addr, input logic [31:0] wdata,
                           input int hmode, input int hdelay, input bit rnd_ready, input int abort_beat);
        int          lat;
        int          nbeats;
        int          spins;
        int          we0;
        int          hr0;
        bit          hs;
        bit          exp_err;
        bit          exp_hr;
        bit          exp_last;
        logic [4:0]  exp_addr;
        logic [31:0] exp_data;
        int          exp_we;

        exp_err    = (op == OP_ILLEGAL) || (hmode == 0);
        exp_hr     = (op != OP_ILLEGAL);
        nbeats     = (op == OP_DUMP && !exp_err) ? NREGS : 1;
        halt_mode  = hmode;
        halt_delay = hdelay;
        we0        = we_total;
        hr0        = hr_total;

        @(negedge clk);
        check_val("cmd_ready_idle", bus.cmd_ready, 1);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_addr  = addr;
        bus.cmd_wdata = wdata;
        bus.rsp_ready = 1'b0;

        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            if (lat == 1) bus.cmd_valid = 1'b0;
        end while (!bus.rsp_valid && lat < 64);
        check_val("rsp_wait_bound", bus.rsp_valid, 1);
        if (!bus.rsp_valid) return;

        if (op == OP_ILLEGAL)  check_val("lat_illegal", lat, 1);
        else if (hmode == 0)   check_val("lat_timeout_window", (lat >= 15 && lat <= 17), 1);
        else                   check_val("lat_first", lat, 3 + ((hmode == 2) ? hdelay : 0));

        for (int beat = 0; beat < nbeats; beat++) begin
            if (beat > 0) begin
                lat = 1;
                while (!bus.rsp_valid && lat < 64) begin
                    check_val("dump_halt_hold", dbg_halt_req, 1);
                    @(negedge clk);
                    lat++;
                end
                check_val("dump_beat_lat", lat, 2);
                if (!bus.rsp_valid) return;
            end

            if (beat == abort_beat) begin
                rst = 1'b0;
                #1;
                check_all_zero("mid_reset");
                return;
            end

            if (exp_err) begin
                exp_addr = addr;
                exp_data = 32'd0;
                exp_last = 1'b1;
            end else if (op == OP_DUMP) begin
                exp_addr = 5'(beat);
                exp_data = ref_regs[beat];
                exp_last = (beat == NREGS - 1);
            end else if (op == OP_WRITE) begin
                exp_addr = addr;
                exp_data = (addr == 5'd0) ? 32'd0 : wdata;
                exp_last = 1'b1;
            end else begin
                exp_addr = addr;
                exp_data = ref_regs[addr];
                exp_last = 1'b1;
            end

            hs    = 1'b0;
            spins = 0;
            while (!hs && spins < 64) begin
                check_val("rsp_valid_hold", bus.rsp_valid, 1);
                check_val("rsp_err",  bus.rsp_err,  exp_err);
                check_val("rsp_last", bus.rsp_last, exp_last);
                check_val("rsp_data", bus.rsp_data, exp_data);
                if (!exp_err) check_val("rsp_addr", bus.rsp_addr, exp_addr);
                check_val("halt_req_in_resp", dbg_halt_req, exp_hr);
                check_val("raddr_outside_exec", rf_raddr, 0);
                check_val("we_outside_exec", rf_we, 0);
                bus.rsp_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
                hs = bus.rsp_ready;
                @(negedge clk);
                bus.rsp_ready = 1'b0;
                spins++;
            end
            check_val("handshake_bound", hs, 1);
            if (!hs) return;
        end

        check_val("halt_drop_after_last", dbg_halt_req, 0);
        check_val("cmd_ready_after_last", bus.cmd_ready, 1);
        check_val("rsp_valid_after_last", bus.rsp_valid, 0);

        exp_we = (op == OP_WRITE && !exp_err && addr != 5'd0) ? 1 : 0;
        check_val("we_pulse_count", we_total - we0, exp_we);
        if (exp_we == 1) begin
            check_val("we_addr", we_last_addr, addr);
            check_val("we_data", we_last_data, wdata);
            ref_regs[addr] = wdata;
        end
        if (op == OP_ILLEGAL) check_val("illegal_no_halt", hr_total - hr0, 0);
    endtask

    initial begin
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 2'b00;
        bus.cmd_addr  = 5'd0;
        bus.cmd_wdata = 32'd0;
        bus.rsp_ready = 1'b0;
        for (int i = 0; i < NREGS; i++) ref_regs[i] = (i == 0) ? 32'd0 : $urandom;
        ref_regs[1] = 32'h0000EE00;
        preload = 1'b1;
        repeat (2) @(negedge clk);
        preload = 1'b0;
        check_all_zero("reset");
        rst = 1'b1;
        @(negedge clk);
        check_val("cmd_ready_after_reset", bus.cmd_ready, 1);

        run_cmd(OP_READ,    5'd1, 32'd0,         1, 0, 1'b0, -1);
        run_cmd(OP_WRITE,   5'd5, 32'hDEADBEEF,  1, 0, 1'b0, -1);
        run_cmd(OP_READ,    5'd5, 32'd0,         1, 0, 1'b0, -1);
        run_cmd(OP_WRITE,   5'd0, 32'h00001234,  1, 0, 1'b0, -1);
        run_cmd(OP_READ,    5'd0, 32'd0,         1, 0, 1'b0, -1);
        run_cmd(OP_DUMP,    5'd7, 32'd0,         1, 0, 1'b1, -1);
        run_cmd(OP_READ,    5'd3, 32'd0,         0, 0, 1'b0, -1);
        run_cmd(OP_WRITE,   5'd9, 32'hCAFEF00D,  0, 0, 1'b1, -1);
        run_cmd(OP_ILLEGAL, 5'd9, 32'h55555555,  1, 0, 1'b1, -1);
        run_cmd(OP_WRITE,   5'd31, 32'h0BADC0DE, 2, 4, 1'b1, -1);
        run_cmd(OP_READ,    5'd31, 32'd0,        2, 2, 1'b0, -1);

        run_cmd(OP_DUMP, 5'd0, 32'd0, 1, 0, 1'b0, 10);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_val("cmd_ready_after_midreset", bus.cmd_ready, 1);
        run_cmd(OP_DUMP, 5'd0, 32'd0, 2, 1, 1'b1, -1);

        for (int n = 0; n < 40; n++) begin
            int          sel;
            logic [1:0]  op;
            int          hm;
            sel = $urandom_range(0, 9);
            op  = (sel < 4) ? OP_READ : (sel < 8) ? OP_WRITE : (sel == 8) ? OP_DUMP : OP_ILLEGAL;
            hm  = ($urandom_range(0, 7) == 0) ? 0 : 2;
            run_cmd(op, 5'($urandom_range(0, 31)), $urandom, hm, $urandom_range(0, 6),
                    1'($urandom_range(0, 1)), -1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, compared=%0d", n_cmp);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/reg_file_dbg_port.md
# reg_file_dbg_port

Debug access initiator for the RV32I register file. It halts the core, then drives the register file's read port (`A1`/`RD1`) and write port (`WE3`/`A3`/`WD3`) on behalf of an external debug host. It supports three commands: single read, single write, and a full dump of all registers. It sits between the debug host and the register-file port muxes, and owns those ports only while the core acknowledges halt.

## Interface
Parameters:
- `XLEN`, 32, data width
- `NREGS`, 32, number of architectural registers (address width = clog2(NREGS))
- `HALT_TIMEOUT`, 16, max cycles to wait for `dbg_halted` before the command is aborted with an error

Ports:
- `clk`  in  1  system clock, rising edge
- `rst`  in  1  asynchronous, active-low reset
- `cmd_valid`  in  1  host command valid
- `cmd_ready`  out  1  block can accept a command
- `cmd_op`  in  2  00 read, 01 write, 10 dump, 11 illegal
- `cmd_addr`  in  5  target register (ignored for dump)
- `cmd_wdata`  in  XLEN  write data
- `rsp_valid`  out  1  response valid
- `rsp_ready`  in  1  host accepts response
- `rsp_addr`  out  5  register the response refers to
- `rsp_data`  out  XLEN  read data, or echoed write data
- `rsp_last`  out  1  final response of a command
- `rsp_err`  out  1  illegal op or halt timeout
- `dbg_halt_req`  out  1  request core stall
- `dbg_halted`  in  1  core is stalled; ports are safe to drive
- `rf_raddr`  out  5  drives register file `A1` while halted
- `rf_rdata`  in  XLEN  register file `RD1` (combinational)
- `rf_we`  out  1  drives `WE3`
- `rf_waddr`  out  5  drives `A3`
- `rf_wdata`  out  XLEN  drives `WD3`

## Operation
- FSM states: IDLE, HALT_WAIT, EXEC, RESP.
- **IDLE**
  - `cmd_ready`=1.
  - On accept, latch op, addr and wdata.
  - Ops 00, 01 and 10: set `dbg_halt_req`, clear the timeout counter, go to HALT_WAIT.
  - Op 11: go to RESP with `rsp_err`=1, `rsp_data`=0, `rsp_last`=1. No halt is requested.
- **HALT_WAIT**
  - `dbg_halted`=1 → EXEC.
  - Otherwise increment the timeout counter. When it reaches HALT_TIMEOUT-1, go to RESP with `rsp_err`=1, `rsp_data`=0, `rsp_last`=1.
- **EXEC** (exactly one cycle)
  - Read: `rf_raddr`=addr; capture `rf_rdata` into `rsp_data`.
  - Write: `rf_we`=1 with `rf_waddr`=addr and `rf_wdata`=wdata, unless addr==0. For addr 0, `rf_we` stays 0 and `rsp_data`=0. Otherwise `rsp_data`=wdata.
  - Dump: `rf_raddr`=dump counter; capture `rf_rdata`; `rsp_addr`=counter.
- **RESP**
  - `rsp_valid`=1; all rsp_* outputs are held stable until `rsp_ready`.
  - On handshake, if dump and counter != NREGS-1: increment counter, go to EXEC.
  - Otherwise clear `dbg_halt_req` and go to IDLE.
- `rsp_last`=1 for read, write, error, and the final dump beat (counter==NREGS-1).
- `dbg_halted` is sampled only in HALT_WAIT. A deassertion during EXEC or RESP is ignored.
- `rf_we` is high only in EXEC of a write with addr!=0. `rf_raddr` is 0 outside EXEC.

## Timing
- Reset (`rst`=0, async): state=IDLE.
  - Every output is 0, including `cmd_ready`, which rises the first cycle after reset release.
  - Dump counter and timeout counter reset to 0.
  - Reset mid-command drops `dbg_halt_req` immediately; no response is issued.
- `dbg_halt_req`, rsp_* and rf_* are registered. `cmd_ready` and `rsp_valid` decode from state.
- Accept at edge t:
  - `dbg_halt_req`=1 in cycle t+1.
  - If `dbg_halted`=1 in t+1, EXEC occupies t+2 and `rsp_valid` rises in t+3.
  - Minimum accept-to-response latency is 3 cycles; the write pulse occurs in cycle t+2.
- Dump: each beat after the first takes 2 cycles from handshake to the next `rsp_valid`, so 32 beats take at least 3+31×2 cycles with `rsp_ready` held at 1. `dbg_halt_req` stays high for the whole dump.
- `dbg_halt_req` falls in the cycle after the final handshake. `cmd_ready` rises in that same cycle; back-to-back commands reassert halt one cycle later.
- Illegal op: response appears in t+1.

## Structure
- Shared package `rf_dbg_pkg` holds:
  - op encodings: `OP_READ`, `OP_WRITE`, `OP_DUMP`, `OP_ILLEGAL`
  - FSM state enum
  - register address width constant, shared with the register file
- Single module; no sub-module needed. Both counters are inline.

## Test plan
- Read: preload x1=0x0000EE00; cmd read addr 1; `dbg_halted` tied 1 → single response, `rsp_addr`=1, `rsp_data`=0x0000EE00, `rsp_last`=1, `rsp_err`=0, `rsp_valid` at accept+3.
- Write then read: write addr 5 data 0xDEADBEEF → one-cycle `rf_we` pulse with `rf_waddr`=5; subsequent read of addr 5 returns 0xDEADBEEF. Write to addr 0 data 0x1234 → `rf_we` never asserted, `rsp_data`=0, and a read of x0 returns 0.
- Dump with `rsp_ready` toggling randomly → 32 beats with `rsp_addr` 0..31 in order, data matches the model, `rsp_last` only on beat 31, `dbg_halt_req` continuous until the final handshake.
- Halt timeout: `dbg_halted`=0, HALT_TIMEOUT=16 → `rsp_err`=1, `rsp_data`=0 about 16 cycles after accept; `rf_we` never asserted; `dbg_halt_req` drops after the handshake.
- Illegal op 11 → `rsp_err`=1 at accept+1; `dbg_halt_req` never asserted.
- Async reset asserted mid-dump at beat 10 → all outputs 0 immediately; after release, a fresh dump starts from addr 0.
